// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: instruction record, queue FSM states and
// the combinational decoder for the supported x86-64 subset.
package decode_queue_pkg;

    localparam int MAX_INS_BYTES = 15;

    typedef enum logic {RUN, FLUSH} dq_state_t;

    typedef enum logic [3:0] {
        INS_NONE, INS_NOP, INS_RET, INS_PUSH, INS_POP,
        INS_MOV_RI, INS_ADD_AI, INS_JMP, INS_MOV_RR
    } ins_name_t;

    typedef struct packed {
        ins_name_t  name;
        logic [7:0] opcode;
    } opcode_struct_t;

    typedef struct packed {
        opcode_struct_t opcode_struct;
        logic           rex_w;
        logic [3:0]     dst;
        logic [3:0]     src;
        logic [63:0]    imm;
    } fat_instruction_t;

    // Byte 0 of the window sits in the top bits. Unknown encodings and
    // memory-form ModRM operands come back as INS_NONE with length 1.
    function automatic logic [3:0] decode(input logic [MAX_INS_BYTES*8-1:0] win,
                                          output fat_instruction_t ins);
        logic [7:0]  b [MAX_INS_BYTES];
        logic        rex;
        logic [3:0]  p;
        logic [3:0]  len;
        logic [7:0]  op;
        logic [7:0]  modrm;
        logic [31:0] imm32;
        logic [63:0] imm64;
        for (int k = 0; k < MAX_INS_BYTES; k++)
            b[k] = win[(MAX_INS_BYTES-1-k)*8 +: 8];
        rex   = (b[0][7:4] == 4'h4);
        p     = rex ? 4'd1 : 4'd0;
        op    = rex ? b[1] : b[0];
        modrm = rex ? b[2] : b[1];
        imm32 = rex ? {b[5], b[4], b[3], b[2]} : {b[4], b[3], b[2], b[1]};
        imm64 = rex ? {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]}
                    : {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]};
        ins       = '0;
        len       = 4'd1;
        ins.rex_w = rex & b[0][3];
        casez (op)
            8'h90: begin ins.opcode_struct.name = INS_NOP; len = p + 4'd1; end
            8'hC3: begin ins.opcode_struct.name = INS_RET; len = p + 4'd1; end
            8'b0101_0???: begin
                ins.opcode_struct.name = INS_PUSH;
                ins.dst = {rex & b[0][0], op[2:0]};
                len = p + 4'd1;
            end
            8'b0101_1???: begin
                ins.opcode_struct.name = INS_POP;
                ins.dst = {rex & b[0][0], op[2:0]};
                len = p + 4'd1;
            end
            8'b1011_1???: begin
                ins.opcode_struct.name = INS_MOV_RI;
                ins.dst = {rex & b[0][0], op[2:0]};
                if (ins.rex_w) begin
                    ins.imm = imm64;
                    len = p + 4'd9;
                end else begin
                    ins.imm = {32'h0, imm32};
                    len = p + 4'd5;
                end
            end
            8'h05: begin
                ins.opcode_struct.name = INS_ADD_AI;
                ins.imm = {{32{imm32[31]}}, imm32};
                len = p + 4'd5;
            end
            8'hEB: begin
                ins.opcode_struct.name = INS_JMP;
                ins.imm = {{56{modrm[7]}}, modrm};
                len = p + 4'd2;
            end
            8'hE9: begin
                ins.opcode_struct.name = INS_JMP;
                ins.imm = {{32{imm32[31]}}, imm32};
                len = p + 4'd5;
            end
            8'h89: begin
                if (modrm[7:6] == 2'b11) begin
                    ins.opcode_struct.name = INS_MOV_RR;
                    ins.dst = {rex & b[0][0], modrm[2:0]};
                    ins.src = {rex & b[0][2], modrm[5:3]};
                    len = p + 4'd2;
                end
            end
            default: ;
        endcase
        if (ins.opcode_struct.name == INS_NONE) begin
            ins = '0;
            len = 4'd1;
        end else begin
            ins.opcode_struct.opcode = op;
        end
        return len;
    endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and back-end-side handshake bundle of the decode queue.
interface decode_queue_if #(
    parameter int FETCH_BYTES = 8,
    parameter int ADDR_W      = 64
);
    import decode_queue_pkg::*;

    logic                     fetch_valid;
    logic                     fetch_ready;
    logic [FETCH_BYTES*8-1:0] fetch_bytes;
    logic                     flush;
    logic [ADDR_W-1:0]        flush_pc;
    logic                     out_valid;
    logic                     out_ready;
    fat_instruction_t         out_ins;
    logic [3:0]               out_len;
    logic [ADDR_W-1:0]        out_pc;

    modport master (
        output fetch_valid, fetch_bytes, flush, flush_pc, out_ready,
        input  fetch_ready, out_valid, out_ins, out_len, out_pc
    );

    modport slave (
        input  fetch_valid, fetch_bytes, flush, flush_pc, out_ready,
        output fetch_ready, out_valid, out_ins, out_len, out_pc
    );
endinterface

// File: rtl/decode_queue_byte_ring.sv
// Byte ring for the decode queue: FETCH_BYTES-wide push, variable pop and a
// zero-masked MAX_INS_BYTES window at the read pointer.
module dq_byte_ring
    import decode_queue_pkg::*;
#(
    parameter int BUF_BYTES   = 32,
    parameter int FETCH_BYTES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [FETCH_BYTES*8-1:0]     push_bytes,
    input  logic [3:0]                   pop_len,
    output logic [MAX_INS_BYTES*8-1:0]   window,
    output logic [$clog2(BUF_BYTES):0]   count
);
    localparam int PW = $clog2(BUF_BYTES);
    localparam int CW = PW + 1;

    logic [7:0]    mem [BUF_BYTES];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;

    // Storage has no reset: bytes beyond count are never exposed.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            for (int i = 0; i < FETCH_BYTES; i++)
                mem[wr_ptr_reg + PW'(i)] <= push_bytes[(FETCH_BYTES-1-i)*8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_reg + PW'(pop_len);
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(FETCH_BYTES);
            count_reg <= count_reg + (push ? CW'(FETCH_BYTES) : CW'(0)) - CW'(pop_len);
        end
    end

    for (genvar gi = 0; gi < MAX_INS_BYTES; gi++) begin : g_window
        assign window[(MAX_INS_BYTES-1-gi)*8 +: 8] =
            (CW'(gi) < count_reg) ? mem[rd_ptr_reg + PW'(gi)] : 8'h00;
    end

    assign count = count_reg;
endmodule

// File: rtl/decode_queue.sv
// Buffered x86-64 decode stage: byte ring, head decoder, output register and PC.
// Optional DECODE_STATS_EN adds emitted-instruction and skipped-byte counters.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int FETCH_BYTES = 8,
    parameter int BUF_BYTES   = 32,
    parameter int ADDR_W      = 64
) (
    input  logic           clk,
    input  logic           reset,
    decode_queue_if.slave  dq
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0]    stat_ins_cnt,
    output logic [31:0]    stat_skip_cnt
`endif
);
    localparam int CW = $clog2(BUF_BYTES) + 1;

    dq_state_t                      state_reg;
    logic [ADDR_W-1:0]              head_pc_reg;
    logic                           out_valid_reg;
    fat_instruction_t               out_ins_reg;
    logic [3:0]                     out_len_reg;
    logic [ADDR_W-1:0]              out_pc_reg;

    logic [MAX_INS_BYTES*8-1:0]     window;
    logic [CW-1:0]                  count;
    fat_instruction_t               dec_ins;
    logic [3:0]                     dec_len;
    logic                           head_usable;
    logic                           do_skip;
    logic                           do_load;
    logic                           push;
    logic [3:0]                     pop_len;

    assign dq.fetch_ready = !reset && (state_reg == RUN) &&
                            (count <= CW'(BUF_BYTES - FETCH_BYTES));
    assign push = dq.fetch_valid && dq.fetch_ready && !dq.flush;

    always_comb begin
        dec_len     = decode(window, dec_ins);
        head_usable = (count != '0) && (CW'(dec_len) <= count);
        do_skip     = !dq.flush && (state_reg == RUN) && head_usable &&
                      (dec_ins.opcode_struct.name == INS_NONE);
        do_load     = !dq.flush && (state_reg == RUN) && head_usable &&
                      (dec_ins.opcode_struct.name != INS_NONE) &&
                      (!out_valid_reg || dq.out_ready);
        pop_len     = do_skip ? 4'd1 : (do_load ? dec_len : 4'd0);
    end

    dq_byte_ring #(
        .BUF_BYTES  (BUF_BYTES),
        .FETCH_BYTES(FETCH_BYTES)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .clear     (dq.flush),
        .push      (push),
        .push_bytes(dq.fetch_bytes),
        .pop_len   (pop_len),
        .window    (window),
        .count     (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= RUN;
            head_pc_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_ins_reg   <= '0;
            out_len_reg   <= '0;
            out_pc_reg    <= '0;
        end else if (dq.flush) begin
            state_reg     <= FLUSH;
            head_pc_reg   <= dq.flush_pc;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg   <= RUN;
            head_pc_reg <= head_pc_reg + ADDR_W'(pop_len);
            if (do_load) begin
                out_valid_reg <= 1'b1;
                out_ins_reg   <= dec_ins;
                out_len_reg   <= dec_len;
                out_pc_reg    <= head_pc_reg;
            end else if (dq.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign dq.out_valid = out_valid_reg;
    assign dq.out_ins   = out_ins_reg;
    assign dq.out_len   = out_len_reg;
    assign dq.out_pc    = out_pc_reg;

`ifdef DECODE_STATS_EN
    logic [31:0] ins_cnt_reg;
    logic [31:0] skip_cnt_reg;

    // Flush deliberately leaves the counters alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_cnt_reg  <= '0;
            skip_cnt_reg <= '0;
        end else begin
            if (do_load)
                ins_cnt_reg <= ins_cnt_reg + 32'd1;
            if (do_skip)
                skip_cnt_reg <= skip_cnt_reg + 32'd1;
        end
    end

    assign stat_ins_cnt  = ins_cnt_reg;
    assign stat_skip_cnt = skip_cnt_reg;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: latency, split instructions, skips,
// back-pressure, flush, ring wrap with a 100-instruction stream, and reset.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int FB = 8;
    localparam int BB = 32;
    localparam int AW = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_queue_if #(.FETCH_BYTES(FB), .ADDR_W(AW)) dq_if ();

`ifdef DECODE_STATS_EN
    logic [31:0] stat_ins_cnt;
    logic [31:0] stat_skip_cnt;
`endif

    decode_queue #(.FETCH_BYTES(FB), .BUF_BYTES(BB), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .dq           (dq_if)
`ifdef DECODE_STATS_EN
        ,
        .stat_ins_cnt (stat_ins_cnt),
        .stat_skip_cnt(stat_skip_cnt)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  len;
        ins_name_t   name;
        logic [63:0] imm;
    } rx_t;

    rx_t        rx_q [$];
    rx_t        exp_q [$];
    logic [7:0] stream [$];
    int errors = 0;
    int checks = 0;

    // Consumer side: outputs taken at the coming edge, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && dq_if.out_valid && dq_if.out_ready) begin
            rx_t r;
            r.pc   = dq_if.out_pc;
            r.len  = dq_if.out_len;
            r.name = dq_if.out_ins.opcode_struct.name;
            r.imm  = dq_if.out_ins.imm;
            rx_q.push_back(r);
            $display("rx pc=%h len=%0d name=%0d imm=%h", r.pc, r.len, r.name, r.imm);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_flush(input logic [63:0] pc);
        dq_if.flush    = 1'b1;
        dq_if.flush_pc = pc;
        tick();
        dq_if.flush = 1'b0;
        tick();
        rx_q.delete();
    endtask

    task automatic send(input logic [63:0] w);
        int n = 0;
        dq_if.fetch_valid = 1'b1;
        dq_if.fetch_bytes = w;
        while (!dq_if.fetch_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", dq_if.fetch_ready, 1);
        tick();
        dq_if.fetch_valid = 1'b0;
    endtask

    initial begin
        int pushes;
        int pos;
        logic [63:0] pc;
        logic [31:0] v;
        logic [7:0]  r8;
        logic        took;

        reset = 1'b1;
        dq_if.fetch_valid = 1'b0;
        dq_if.fetch_bytes = '0;
        dq_if.flush       = 1'b0;
        dq_if.flush_pc    = '0;
        dq_if.out_ready   = 1'b1;
        run(3);

        // Reset state
        check("rst_fetch_ready", dq_if.fetch_ready, 0);
        check("rst_out_valid", dq_if.out_valid, 0);
        check("rst_out_pc", dq_if.out_pc, 0);
        check("rst_out_len", dq_if.out_len, 0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", dq_if.fetch_ready, 1);

        // Test 1: eight NOPs, first output one cycle after the fetch edge
        do_flush(64'h1000);
        dq_if.fetch_valid = 1'b1;
        dq_if.fetch_bytes = 64'h9090_9090_9090_9090;
        tick();
        dq_if.fetch_valid = 1'b0;
        check("t1_lat_valid0", dq_if.out_valid, 0);
        tick();
        check("t1_lat_valid1", dq_if.out_valid, 1);
        check("t1_first_pc", dq_if.out_pc, 64'h1000);
        check("t1_first_len", dq_if.out_len, 1);
        run(10);
        check("t1_count", rx_q.size(), 8);
        for (int i = 0; i < rx_q.size() && i < 8; i++)
            check($sformatf("t1_pc[%0d]", i), rx_q[i].pc, 64'h1000 + 64'(i));

        // Test 2: 10-byte mov r64,imm64 split across two fetches
        do_flush(64'h3000);
        send(64'h48B8_1122_3344_5566);
        for (int i = 0; i < 3; i++) begin
            check("t2_stall", dq_if.out_valid, 0);
            tick();
        end
        send(64'h7788_9090_9090_9090);
        run(12);
        check("t2_count", rx_q.size(), 7);
        if (rx_q.size() >= 2) begin
            check("t2_len", rx_q[0].len, 10);
            check("t2_pc", rx_q[0].pc, 64'h3000);
            check("t2_name", rx_q[0].name, INS_MOV_RI);
            check("t2_imm", rx_q[0].imm, 64'h8877_6655_4433_2211);
            check("t2_next_pc", rx_q[1].pc, 64'h300A);
        end

        // Test 3: undefined byte and memory-form ModRM are skipped
        do_flush(64'h4000);
        send(64'h0F89_0090_89C8_9090);
        run(12);
        check("t3_count", rx_q.size(), 4);
        if (rx_q.size() >= 3) begin
            check("t3_pc0", rx_q[0].pc, 64'h4003);
            check("t3_pc1", rx_q[1].pc, 64'h4004);
            check("t3_len1", rx_q[1].len, 2);
            check("t3_name1", rx_q[1].name, INS_MOV_RR);
            check("t3_pc2", rx_q[2].pc, 64'h4006);
        end
`ifdef DECODE_STATS_EN
        check("t3_skip_cnt", stat_skip_cnt, 3);
        check("t3_ins_cnt", stat_ins_cnt, 19);
`endif

        // Test 4: back-pressure with a full ring
        do_flush(64'h5000);
        dq_if.out_ready   = 1'b0;
        dq_if.fetch_valid = 1'b1;
        dq_if.fetch_bytes = 64'h9090_9090_9090_9090;
        pushes = 0;
        for (int i = 0; i < 10; i++) begin
            if (dq_if.fetch_ready) pushes++;
            tick();
        end
        check("t4_pushes", pushes, 4);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_ready", dq_if.fetch_ready, 0);
            check("t4_hold_valid", dq_if.out_valid, 1);
            check("t4_hold_pc", dq_if.out_pc, 64'h5000);
            tick();
        end
        dq_if.fetch_valid = 1'b0;
        dq_if.out_ready   = 1'b1;
        run(40);
        check("t4_count", rx_q.size(), 32);
        for (int i = 0; i < rx_q.size() && i < 32; i++)
            check($sformatf("t4_pc[%0d]", i), rx_q[i].pc, 64'h5000 + 64'(i));

        // Test 5: flush beats a pending fetch and a held output
        do_flush(64'h7000);
        dq_if.out_ready = 1'b0;
        send(64'h9090_9090_9090_9090);
        run(2);
        check("t5_pre_valid", dq_if.out_valid, 1);
        dq_if.flush       = 1'b1;
        dq_if.flush_pc    = 64'h2000;
        dq_if.fetch_valid = 1'b1;
        dq_if.fetch_bytes = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        dq_if.flush = 1'b0;
        check("t5_valid_drop", dq_if.out_valid, 0);
        check("t5_ready_flush", dq_if.fetch_ready, 0);
        tick();
        dq_if.fetch_valid = 1'b0;
        rx_q.delete();
        dq_if.out_ready = 1'b1;
        run(3);
        check("t5_empty", dq_if.out_valid, 0);
        send(64'h9090_9090_9090_9090);
        run(10);
        check("t5_count", rx_q.size(), 8);
        if (rx_q.size() >= 1)
            check("t5_pc", rx_q[0].pc, 64'h2000);

        // Test 6: 100 mixed-length instructions across many pointer wraps
        pc = 64'h8000;
        stream.delete();
        exp_q.delete();
        for (int i = 0; i < 100; i++) begin
            rx_t e;
            e.pc  = pc;
            e.imm = '0;
            case ((i * 3) % 7)
                0: begin stream.push_back(8'h90); e.len = 1; e.name = INS_NOP; end
                1: begin stream.push_back(8'h50 | 8'(i & 7)); e.len = 1; e.name = INS_PUSH; end
                2: begin
                    v = 32'(i) * 32'h0102_0304;
                    stream.push_back(8'hB8 | 8'(i & 7));
                    stream.push_back(v[7:0]);   stream.push_back(v[15:8]);
                    stream.push_back(v[23:16]); stream.push_back(v[31:24]);
                    e.len = 5; e.name = INS_MOV_RI; e.imm = {32'h0, v};
                end
                3: begin
                    r8 = 8'(i * 37);
                    stream.push_back(8'hEB); stream.push_back(r8);
                    e.len = 2; e.name = INS_JMP; e.imm = {{56{r8[7]}}, r8};
                end
                4: begin
                    v = 32'h8000_0000 | 32'(i);
                    stream.push_back(8'h05);
                    stream.push_back(v[7:0]);   stream.push_back(v[15:8]);
                    stream.push_back(v[23:16]); stream.push_back(v[31:24]);
                    e.len = 5; e.name = INS_ADD_AI; e.imm = {32'hFFFF_FFFF, v};
                end
                5: begin stream.push_back(8'hC3); e.len = 1; e.name = INS_RET; end
                default: begin
                    v = 32'(i) * 32'h11;
                    stream.push_back(8'hE9);
                    stream.push_back(v[7:0]);   stream.push_back(v[15:8]);
                    stream.push_back(v[23:16]); stream.push_back(v[31:24]);
                    e.len = 5; e.name = INS_JMP; e.imm = {32'h0, v};
                end
            endcase
            pc = pc + 64'(e.len);
            exp_q.push_back(e);
        end
        while (stream.size() % FB != 0) stream.push_back(8'h90);

        do_flush(64'h8000);
        pos = 0;
        for (int cyc = 0; cyc < 3000 && rx_q.size() < 100; cyc++) begin
            dq_if.out_ready = (cyc % 5 != 2);
            if (pos < stream.size()) begin
                dq_if.fetch_valid = 1'b1;
                for (int j = 0; j < FB; j++)
                    dq_if.fetch_bytes[(FB-1-j)*8 +: 8] = stream[pos + j];
            end else begin
                dq_if.fetch_valid = 1'b0;
            end
            took = dq_if.fetch_valid && dq_if.fetch_ready;
            tick();
            if (took) pos += FB;
        end
        dq_if.fetch_valid = 1'b0;
        dq_if.out_ready   = 1'b1;
        check("t6_count", rx_q.size() >= 100, 1);
        for (int i = 0; i < 100 && i < rx_q.size(); i++) begin
            check($sformatf("t6_pc[%0d]", i), rx_q[i].pc, exp_q[i].pc);
            check($sformatf("t6_len[%0d]", i), rx_q[i].len, exp_q[i].len);
            check($sformatf("t6_name[%0d]", i), rx_q[i].name, exp_q[i].name);
            check($sformatf("t6_imm[%0d]", i), rx_q[i].imm, exp_q[i].imm);
        end
        run(20);

        // Test 7: asynchronous reset mid-stream
        do_flush(64'h9000);
        dq_if.out_ready = 1'b0;
        send(64'h9090_9090_9090_9090);
        run(2);
        check("t7_pre_valid", dq_if.out_valid, 1);
        reset = 1'b1;
        #2;
        check("t7_rst_valid", dq_if.out_valid, 0);
        check("t7_rst_pc", dq_if.out_pc, 0);
        check("t7_rst_ready", dq_if.fetch_ready, 0);
`ifdef DECODE_STATS_EN
        check("t7_rst_ins_cnt", stat_ins_cnt, 0);
        check("t7_rst_skip_cnt", stat_skip_cnt, 0);
`endif
        tick();
        reset = 1'b0;
        dq_if.out_ready = 1'b1;
        run(3);
        check("t7_post_valid", dq_if.out_valid, 0);
        check("t7_post_ready", dq_if.fetch_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
